// File: rtl/vec_pkg.sv
// Shared types and constants for the 4-lane dot-product operand path.
package vec_pkg;

  localparam int VEC_LANES  = 4;
  localparam int VEC_LANE_W = 32;
  localparam int VEC_W      = VEC_LANES * VEC_LANE_W;
  localparam int VEC_CNT_W  = $clog2(VEC_LANES) + 1;

  typedef logic [VEC_LANE_W-1:0] lane_t;
  typedef logic [VEC_W-1:0]      vec_t;
  typedef logic [VEC_CNT_W-1:0]  lane_cnt_t;

  // FILL: gathering lanes. HOLD: a completed vector waits for the output register.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_t;

  // Saturating 16-bit increment for event counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/vec_out_reg.sv
// One-entry valid/ready register. Loads whenever it is empty or its current
// entry is leaving this cycle, so back-to-back traffic has no bubble.
// Handshake: a beat moves when valid && ready are both high at a rising edge;
// a producer holds valid and data stable until that edge.
module vec_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Next entry: replace on load, otherwise drain on a downstream handshake.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Entry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/vec_operand_packer.sv
// Packs scalar (a, b) operand pairs into LANES-wide vectors, lane 0 in the
// low bits. A vector closes on the last lane or on in_last; unused upper lanes
// are zero. Optional macro VEC_PACK_PERF_EN adds saturating counters for
// delivered vectors and cycles spent in HOLD.
// Handshake: input and output streams both transfer on valid && ready at a
// rising edge; in_ready depends only on the packer state, never on out_ready.
module vec_operand_packer
  import vec_pkg::*;
#(
  parameter int LANES  = VEC_LANES,
  parameter int LANE_W = VEC_LANE_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANE_W-1:0]         in_a,
  input  logic [LANE_W-1:0]         in_b,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*LANE_W-1:0]   vec_a,
  output logic [LANES*LANE_W-1:0]   vec_b,
  output logic [$clog2(LANES):0]    out_lanes,
  output pack_state_t               dbg_state
`ifdef VEC_PACK_PERF_EN
  ,
  output logic [15:0]               perf_vec_cnt,
  output logic [15:0]               perf_stall_cnt
`endif
);

  localparam int VW = LANES * LANE_W;
  localparam int IW = $clog2(LANES);
  localparam int CW = IW + 1;
  localparam int DW = 2 * VW + CW;

  pack_state_t     state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [VW-1:0]   buf_a_q, buf_a_d;
  logic [VW-1:0]   buf_b_q, buf_b_d;
  logic [VW-1:0]   fill_a, fill_b;
  logic            accept, complete;
  logic            push_valid, push_ready;
  logic [VW-1:0]   push_a, push_b;
  logic [CW-1:0]   push_lanes;
  logic [DW-1:0]   push_data, out_data;

  assign in_ready  = (state_q == FILL);
  assign dbg_state = state_q;
  assign accept    = in_valid && in_ready;
  assign complete  = accept && (in_last || (idx_q == IW'(LANES - 1)));

  // In HOLD idx still points at the closing lane, so the count is the same.
  assign push_lanes = CW'(idx_q) + CW'(1);

  // Fill buffer with the incoming pair merged into lane idx.
  always_comb begin
    fill_a = buf_a_q;
    fill_b = buf_b_q;
    fill_a[int'(idx_q) * LANE_W +: LANE_W] = in_a;
    fill_b[int'(idx_q) * LANE_W +: LANE_W] = in_b;
  end

  // A closing accept offers the merged vector directly; HOLD re-offers the buffer.
  always_comb begin
    push_valid = complete || (state_q == HOLD);
    push_a     = (state_q == HOLD) ? buf_a_q : fill_a;
    push_b     = (state_q == HOLD) ? buf_b_q : fill_b;
    push_data  = {push_lanes, push_a, push_b};
  end

  // Packer FSM next state: fill lanes, hand off or park a completed vector.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_a_d = buf_a_q;
    buf_b_d = buf_b_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          if (complete) begin
            if (push_ready) begin
              idx_d   = '0;
              buf_a_d = '0;
              buf_b_d = '0;
            end else begin
              buf_a_d = fill_a;
              buf_b_d = fill_b;
              state_d = HOLD;
            end
          end else begin
            buf_a_d = fill_a;
            buf_b_d = fill_b;
            idx_d   = idx_q + IW'(1);
          end
        end
      end
      HOLD: begin
        if (push_ready) begin
          idx_d   = '0;
          buf_a_d = '0;
          buf_b_d = '0;
          state_d = FILL;
        end
      end
      default: begin
        state_d = FILL;
        idx_d   = '0;
        buf_a_d = '0;
        buf_b_d = '0;
      end
    endcase
  end

  // Packer state and fill buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      idx_q   <= '0;
      buf_a_q <= '0;
      buf_b_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_a_q <= buf_a_d;
      buf_b_q <= buf_b_d;
    end
  end

  vec_out_reg #(
    .W (DW)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (push_valid),
    .in_ready  (push_ready),
    .in_data   (push_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  assign {out_lanes, vec_a, vec_b} = out_data;

`ifdef VEC_PACK_PERF_EN
  logic [15:0] vec_cnt_q, vec_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Count delivered vectors and HOLD cycles, both saturating.
  always_comb begin
    vec_cnt_d   = (out_valid && out_ready) ? sat_inc16(vec_cnt_q) : vec_cnt_q;
    stall_cnt_d = (state_q == HOLD) ? sat_inc16(stall_cnt_q) : stall_cnt_q;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      vec_cnt_q   <= vec_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_vec_cnt   = vec_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_vec_operand_packer.sv
// Bench for vec_operand_packer: directed vector table, backpressure/HOLD,
// steady streaming, asynchronous reset mid-fill and a randomized run against
// a queue-based reference model.
module tb_vec_operand_packer;
  import vec_pkg::*;

  localparam int L  = 4;
  localparam int LW = 32;
  localparam int VW = L * LW;
  localparam int CW = 3;
  localparam int SW = 2 * VW + CW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, in_last;
  logic [LW-1:0] in_a, in_b;
  logic          out_valid, out_ready;
  logic [VW-1:0] vec_a, vec_b;
  logic [CW-1:0] out_lanes;
  pack_state_t   dbg_state;
`ifdef VEC_PACK_PERF_EN
  logic [15:0]   perf_vec_cnt, perf_stall_cnt;
`endif

  vec_operand_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .vec_a     (vec_a),
    .vec_b     (vec_b),
    .out_lanes (out_lanes),
    .dbg_state (dbg_state)
`ifdef VEC_PACK_PERF_EN
    ,
    .perf_vec_cnt   (perf_vec_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  lane_t          pa[$];
  lane_t          pb[$];
  logic [SW-1:0]  exp_q[$];

  // Accepted pair: collect lanes; a full or last-marked group becomes a vector.
  task automatic model_accept(input lane_t a, input lane_t b, input logic last);
    logic [VW-1:0] va, vb;
    int n;
    pa.push_back(a);
    pb.push_back(b);
    if (pa.size() == L || last) begin
      va = '0;
      vb = '0;
      n  = pa.size();
      for (int i = 0; i < n; i++) begin
        va = va | (VW'(pa[i]) << (LW * i));
        vb = vb | (VW'(pb[i]) << (LW * i));
      end
      exp_q.push_back({CW'(n), va, vb});
      pa.delete();
      pb.delete();
    end
  endtask

  task automatic model_clear();
    pa.delete();
    pb.delete();
    exp_q.delete();
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp_v);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  int            cyc = 0;
  int            hs_cnt = 0;
  logic          hold_chk = 1'b0;
  logic [SW-1:0] hold_val, mon_got, mon_exp;
  logic          bf_on = 1'b0;
  int            bf_last = -1;
  int            bf_bad_gap = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Sampled on the falling edge: what is seen here transfers at the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_chk = 1'b0;
    end else begin
      mon_got = {out_lanes, vec_a, vec_b};
      if (hold_chk) begin
        total++;
        if (!out_valid || mon_got !== hold_val) begin
          bad++;
          $display("FAIL out_stable: valid=%0b got=%0h want=%0h", out_valid, mon_got, hold_val);
        end
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL out_vec: unexpected vector got=%0h", mon_got);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            bad++;
            $display("FAIL out_vec: got=%0h want=%0h", mon_got, mon_exp);
          end
        end
        if (bf_on) begin
          if (bf_last >= 0 && (cyc - bf_last) != L) bf_bad_gap++;
          bf_last = cyc;
        end
      end
      hold_chk = out_valid && !out_ready;
      hold_val = mon_got;
    end
  end

  // ---------------- driver tasks ----------------
  int stall_waits = 0;

  // Present one pair at posedge+1 and return at posedge+1 after it is taken.
  task automatic send(input lane_t a, input lane_t b, input logic last);
    int w;
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready=%0b want=1", in_ready);
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
    end else begin
      if (w > 0) stall_waits++;
      @(posedge clk); #1;
      model_accept(a, b, last);
      in_valid = 1'b0; in_last = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    in_valid = 1'b0; in_last = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    int k;
    out_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("drain_empty", 256'(exp_q.size()), 256'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0][31:0] a;
    logic [3:0][31:0] b;
    int               n;
    logic             last;
    logic [VW-1:0]    ea;
    logic [VW-1:0]    eb;
    logic [CW-1:0]    el;
  } vcase_t;

  vcase_t cases[5];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic acc;
    int   n_sent, hs0;

    cases[0].a = {32'd4, 32'd3, 32'd2, 32'd1};
    cases[0].b = {32'd8, 32'd7, 32'd6, 32'd5};
    cases[0].n = 4; cases[0].last = 1'b0;
    cases[0].ea = 128'h00000004_00000003_00000002_00000001;
    cases[0].eb = 128'h00000008_00000007_00000006_00000005;
    cases[0].el = 3'd4;

    cases[1].a = {32'd0, 32'd0, 32'd3, 32'hFFFFFFFF};
    cases[1].b = {32'd0, 32'd0, 32'd3, 32'd2};
    cases[1].n = 2; cases[1].last = 1'b1;
    cases[1].ea = 128'h00000000_00000000_00000003_FFFFFFFF;
    cases[1].eb = 128'h00000000_00000000_00000003_00000002;
    cases[1].el = 3'd2;

    cases[2].a = {32'd0, 32'd0, 32'd0, 32'h80000000};
    cases[2].b = {32'd0, 32'd0, 32'd0, 32'h7FFFFFFF};
    cases[2].n = 1; cases[2].last = 1'b1;
    cases[2].ea = 128'h80000000;
    cases[2].eb = 128'h7FFFFFFF;
    cases[2].el = 3'd1;

    cases[3].a = {32'd0, 32'h55, 32'h33, 32'h11};
    cases[3].b = {32'd0, 32'h66, 32'h44, 32'h22};
    cases[3].n = 3; cases[3].last = 1'b1;
    cases[3].ea = 128'h00000000_00000055_00000033_00000011;
    cases[3].eb = 128'h00000000_00000066_00000044_00000022;
    cases[3].el = 3'd3;

    cases[4].a = {32'h12345678, 32'hFFFFFFFF, 32'h0, 32'hDEADBEEF};
    cases[4].b = {32'h87654321, 32'hFFFFFFFE, 32'h1, 32'hCAFEBABE};
    cases[4].n = 4; cases[4].last = 1'b1;
    cases[4].ea = 128'h12345678_FFFFFFFF_00000000_DEADBEEF;
    cases[4].eb = 128'h87654321_FFFFFFFE_00000001_CAFEBABE;
    cases[4].el = 3'd4;

    in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
    out_ready = 1'b0; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset values
    check("rst_out_valid", 256'(out_valid), 256'd0);
    check("rst_in_ready",  256'(in_ready),  256'd1);
    check("rst_vec_a",     256'(vec_a),     256'd0);
    check("rst_vec_b",     256'(vec_b),     256'd0);
    check("rst_out_lanes", 256'(out_lanes), 256'd0);

    // Directed table, output free: vector visible one clock after the closing pair
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < cases[c].n; i++)
        send(cases[c].a[i], cases[c].b[i], cases[c].last && (i == cases[c].n - 1));
      check("tbl_out_valid", 256'(out_valid), 256'd1);
      check("tbl_vec_a",     256'(vec_a),     256'(cases[c].ea));
      check("tbl_vec_b",     256'(vec_b),     256'(cases[c].eb));
      check("tbl_out_lanes", 256'(out_lanes), 256'(cases[c].el));
    end
    wait_drain();

    // Backpressure: second vector parks in HOLD until the output frees
    do_reset();
    out_ready = 1'b0;
    hs0 = hs_cnt;
    for (int i = 1; i <= 8; i++) send(32'h10 + 32'(i), 32'h20 + 32'(i), 1'b0);
    check("bp_in_ready_hold", 256'(in_ready),  256'd0);
    check("bp_held_vec_a",    256'(vec_a),     256'(128'h00000014_00000013_00000012_00000011));
    check("bp_held_lanes",    256'(out_lanes), 256'd4);
    repeat (4) @(posedge clk);
    #1;
    check("bp_still_hold", 256'(in_ready), 256'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_in_ready_back", 256'(in_ready), 256'd1);
    check("bp_second_vec_a",  256'(vec_a), 256'(128'h00000018_00000017_00000016_00000015));
    for (int i = 0; i < 4; i++) send(32'h30 + 32'(i), 32'h40 + 32'(i), 1'b0);
    wait_drain();
    check("bp_vec_count", 256'(hs_cnt - hs0), 256'd3);
`ifdef VEC_PACK_PERF_EN
    check("perf_vec_cnt",   256'(perf_vec_cnt),   256'd3);
    check("perf_stall_cnt", 256'(perf_stall_cnt), 256'd5);
`endif

    // Steady streaming: 16 pairs, no input stalls, one vector every LANES cycles
    do_reset();
    out_ready = 1'b1;
    stall_waits = 0; bf_last = -1; bf_bad_gap = 0;
    hs0 = hs_cnt;
    bf_on = 1'b1;
    for (int i = 0; i < 16; i++) send($urandom, $urandom, 1'b0);
    @(posedge clk); #1;
    bf_on = 1'b0;
    check("bf_in_stalls", 256'(stall_waits),   256'd0);
    check("bf_vec_count", 256'(hs_cnt - hs0),  256'd4);
    check("bf_cadence",   256'(bf_bad_gap),    256'd0);
    wait_drain();

    // Asynchronous reset with a held output vector and a partial fill
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(32'h100 + 32'(i), 32'h200 + 32'(i), 1'b0);
    check("mr_pre_valid", 256'(out_valid), 256'd1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mr_async_valid", 256'(out_valid), 256'd0);
    check("mr_async_vec_a", 256'(vec_a),     256'd0);
    check("mr_in_ready",    256'(in_ready),  256'd1);
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("mr_no_emit", 256'(out_valid), 256'd0);
    end
    for (int i = 0; i < 4; i++) send(32'hA0 + 32'(i), 32'hB0 + 32'(i), 1'b0);
    check("mr_new_vec_a", 256'(vec_a), 256'(128'h000000A3_000000A2_000000A1_000000A0));
    check("mr_new_vec_b", 256'(vec_b), 256'(128'h000000B3_000000B2_000000B1_000000B0));
    wait_drain();

    // Randomized traffic: random gaps, in_last and output backpressure
    do_reset();
    n_sent = 0;
    in_valid = 1'b0;
    for (int k = 0; k < 4000 && (n_sent < 300 || in_valid); k++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        model_accept(in_a, in_b, in_last);
        in_valid = 1'b0; in_last = 1'b0;
        n_sent++;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && n_sent < 300 && $urandom_range(0, 4) != 0) begin
        in_a = $urandom; in_b = $urandom;
        in_last = ($urandom_range(0, 4) == 0);
        in_valid = 1'b1;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("rand_all_sent", 256'(n_sent), 256'd300);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
